// File: rtl/saida_display_pkg.sv
// Shared definitions for the BCD output display: FSM states, command code,
// display limit, double-dabble adjust step and the 7-segment glyph table.
package saida_display_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'b00,
    CONVERTE = 2'b01,
    ATUALIZA = 2'b10
  } estado_t;

  localparam int         MAX_DISPLAY = 999;
  localparam logic [1:0] CMD_SAIDA   = 2'b01;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
  function automatic logic [11:0] dabble_ajuste(input logic [11:0] bcd);
    logic [11:0] res;
    res = 12'd0;
    for (int i = 0; i < 3; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return res;
  endfunction

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}; codes 10-15 are blank.
  function automatic logic [6:0] glifo(input logic [3:0] digito);
    logic [6:0] seg;
    case (digito)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/saida_display_sete_segmentos.sv
// Combinational 7-segment decoder for one BCD digit with selectable polarity.
module sete_segmentos
  import saida_display_pkg::*;
#(
  parameter bit ATIVO_BAIXO = 1'b1
) (
  input  logic [3:0] i_digito,
  output logic [6:0] o_seg
);

  logic [6:0] w_glifo;

  assign w_glifo = glifo(i_digito);
  assign o_seg   = ATIVO_BAIXO ? ~w_glifo : w_glifo;

endmodule

// File: rtl/saida_display.sv
// Memory-mapped 3-digit decimal display: a processor write is converted to BCD
// by a sequential double-dabble and shown on three 7-segment outputs.
module saida_display
  import saida_display_pkg::*;
#(
  parameter int LARGURA         = 10,
  parameter int SEG_ATIVO_BAIXO = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dadosEscrita,
  input  logic [1:0]  entradaSaidaControl,
  output logic [3:0]  unidade,
  output logic [3:0]  dezena,
  output logic [3:0]  centena,
  output logic [6:0]  seg_unidade,
  output logic [6:0]  seg_dezena,
  output logic [6:0]  seg_centena,
  output logic        ocupado,
  output logic        pronto,
  output logic        estouro
);

  localparam int              CW     = $clog2(LARGURA + 1);
  localparam logic [CW-1:0]   ULTIMO = CW'(LARGURA - 1);

  estado_t            r_estado;
  estado_t            w_prox;
  logic [LARGURA-1:0] r_operando;
  logic [11:0]        r_bcd;
  logic [CW-1:0]      r_passo;
  logic               r_ov_conv;
  logic               r_pend_valido;
  logic [LARGURA-1:0] r_pend_dado;
  logic [3:0]         r_unidade;
  logic [3:0]         r_dezena;
  logic [3:0]         r_centena;
  logic               r_pronto;
  logic               r_estouro;
  logic               r_ocupado;

  logic               w_escrita;
  logic               w_carrega;
  logic               w_usa_pend;
  logic               w_passo;
  logic               w_captura;
  logic               w_atualiza;
  logic [LARGURA-1:0] w_fonte;
  logic               w_fonte_ov;
  logic [LARGURA-1:0] w_fonte_sat;
  logic [11:0]        w_bcd_aj;
  logic               w_unused_alto;

  assign w_escrita     = (entradaSaidaControl == CMD_SAIDA);
  assign w_unused_alto = ^dadosEscrita[31:LARGURA];

  // The load source is the live bus unless restarting from the pending buffer.
  assign w_fonte     = w_usa_pend ? r_pend_dado : dadosEscrita[LARGURA-1:0];
  assign w_fonte_ov  = (32'(w_fonte) > 32'(MAX_DISPLAY));
  assign w_fonte_sat = w_fonte_ov ? LARGURA'(MAX_DISPLAY) : w_fonte;
  assign w_bcd_aj    = dabble_ajuste(r_bcd);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox;
    end
  end

  always_comb begin
    w_prox     = r_estado;
    w_carrega  = 1'b0;
    w_usa_pend = 1'b0;
    w_passo    = 1'b0;
    w_captura  = 1'b0;
    w_atualiza = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (w_escrita) begin
          w_carrega = 1'b1;
          w_prox    = CONVERTE;
        end else begin
          w_prox    = OCIOSO;
        end
      end
      CONVERTE: begin
        w_passo   = 1'b1;
        w_captura = w_escrita;
        if (r_passo == ULTIMO) begin
          w_prox = ATUALIZA;
        end else begin
          w_prox = CONVERTE;
        end
      end
      ATUALIZA: begin
        w_atualiza = 1'b1;
        // A write landing here is newer than anything buffered, so it wins.
        if (w_escrita) begin
          w_carrega = 1'b1;
          w_prox    = CONVERTE;
        end else if (r_pend_valido) begin
          w_carrega  = 1'b1;
          w_usa_pend = 1'b1;
          w_prox     = CONVERTE;
        end else begin
          w_prox = OCIOSO;
        end
      end
      default: begin
        w_prox = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_operando    <= '0;
      r_bcd         <= 12'd0;
      r_passo       <= '0;
      r_ov_conv     <= 1'b0;
      r_pend_valido <= 1'b0;
      r_pend_dado   <= '0;
      r_unidade     <= 4'd0;
      r_dezena      <= 4'd0;
      r_centena     <= 4'd0;
      r_pronto      <= 1'b0;
      r_estouro     <= 1'b0;
      r_ocupado     <= 1'b0;
    end else begin
      r_pronto  <= 1'b0;
      r_ocupado <= (w_prox != OCIOSO);

      if (w_carrega) begin
        r_operando <= w_fonte_sat;
        r_bcd      <= 12'd0;
        r_passo    <= '0;
        r_ov_conv  <= w_fonte_ov;
      end else if (w_passo) begin
        {r_bcd, r_operando} <= {w_bcd_aj[10:0], r_operando, 1'b0};
        r_passo             <= r_passo + CW'(1);
      end else begin
        r_passo <= r_passo;
      end

      if (w_carrega) begin
        r_pend_valido <= 1'b0;
      end else if (w_captura) begin
        r_pend_valido <= 1'b1;
        r_pend_dado   <= dadosEscrita[LARGURA-1:0];
      end else begin
        r_pend_valido <= r_pend_valido;
      end

      // Digits only change here, so a partial conversion is never visible.
      if (w_atualiza) begin
        r_unidade <= r_bcd[3:0];
        r_dezena  <= r_bcd[7:4];
        r_centena <= r_bcd[11:8];
        r_estouro <= r_ov_conv;
        r_pronto  <= 1'b1;
      end else begin
        r_estouro <= r_estouro;
      end
    end
  end

  assign unidade = r_unidade;
  assign dezena  = r_dezena;
  assign centena = r_centena;
  assign pronto  = r_pronto;
  assign estouro = r_estouro;
  assign ocupado = r_ocupado;

  sete_segmentos #(.ATIVO_BAIXO(SEG_ATIVO_BAIXO != 0)) u_seg_unidade (
    .i_digito (r_unidade),
    .o_seg    (seg_unidade)
  );

  sete_segmentos #(.ATIVO_BAIXO(SEG_ATIVO_BAIXO != 0)) u_seg_dezena (
    .i_digito (r_dezena),
    .o_seg    (seg_dezena)
  );

  sete_segmentos #(.ATIVO_BAIXO(SEG_ATIVO_BAIXO != 0)) u_seg_centena (
    .i_digito (r_centena),
    .o_seg    (seg_centena)
  );

endmodule

// File: tb/tb_saida_display.sv
// Self-checking bench for saida_display: directed scenarios plus random traffic,
// compared every cycle against a job-level model of write/convert/display.
module tb_saida_display;

  logic        clk;
  logic        reset;
  logic [31:0] dadosEscrita;
  logic [1:0]  entradaSaidaControl;
  logic [3:0]  unidade;
  logic [3:0]  dezena;
  logic [3:0]  centena;
  logic [6:0]  seg_unidade;
  logic [6:0]  seg_dezena;
  logic [6:0]  seg_centena;
  logic        ocupado;
  logic        pronto;
  logic        estouro;

  int n_checks = 0;
  int n_err    = 0;
  int n_pronto = 0;

  // Model: a job converts for 11 edges after its write edge, then displays.
  bit m_busy = 1'b0;
  int m_cnt  = 0;
  int m_cur  = 0;
  bit m_pv   = 1'b0;
  int m_pd   = 0;
  int m_u    = 0;
  int m_d    = 0;
  int m_c    = 0;
  bit m_ov   = 1'b0;
  bit m_pr   = 1'b0;

  saida_display dut (
    .clk                 (clk),
    .reset               (reset),
    .dadosEscrita        (dadosEscrita),
    .entradaSaidaControl (entradaSaidaControl),
    .unidade             (unidade),
    .dezena              (dezena),
    .centena             (centena),
    .seg_unidade         (seg_unidade),
    .seg_dezena          (seg_dezena),
    .seg_centena         (seg_centena),
    .ocupado             (ocupado),
    .pronto              (pronto),
    .estouro             (estouro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_esp(input int d);
    logic [6:0] on;
    case (d)
      0:       on = 7'b0111111;
      1:       on = 7'b0000110;
      2:       on = 7'b1011011;
      3:       on = 7'b1001111;
      4:       on = 7'b1100110;
      5:       on = 7'b1101101;
      6:       on = 7'b1111101;
      7:       on = 7'b0000111;
      8:       on = 7'b1111111;
      9:       on = 7'b1101111;
      default: on = 7'b0000000;
    endcase
    return ~on;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_start(input int v);
    m_cur  = v;
    m_cnt  = 0;
    m_busy = 1'b1;
    m_pv   = 1'b0;
  endtask

  task automatic m_edge(input logic rst, input logic [1:0] ctl, input logic [31:0] dat);
    int v;
    bit wr;
    wr = (ctl == 2'b01);
    v  = int'(dat & 32'h3FF);
    if (rst) begin
      m_busy = 1'b0; m_cnt = 0; m_pv = 1'b0; m_pd = 0;
      m_u = 0; m_d = 0; m_c = 0; m_ov = 1'b0; m_pr = 1'b0;
    end else begin
      m_pr = 1'b0;
      if (!m_busy) begin
        if (wr) m_start(v);
      end else begin
        m_cnt++;
        if (m_cnt == 11) begin
          int s;
          s    = (m_cur > 999) ? 999 : m_cur;
          m_u  = s % 10;
          m_d  = (s / 10) % 10;
          m_c  = s / 100;
          m_ov = (m_cur > 999);
          m_pr = 1'b1;
          if (wr) m_start(v);
          else if (m_pv) m_start(m_pd);
          else m_busy = 1'b0;
        end else if (wr) begin
          m_pv = 1'b1;
          m_pd = v;
        end
      end
    end
  endtask

  task automatic tick(input logic rst, input logic [1:0] ctl, input logic [31:0] dat);
    reset               = rst;
    entradaSaidaControl = ctl;
    dadosEscrita        = dat;
    @(posedge clk);
    m_edge(rst, ctl, dat);
    #1;
    if (pronto === 1'b1) n_pronto++;
    chk("ocupado", 32'(ocupado), 32'(m_busy));
    chk("pronto", 32'(pronto), 32'(m_pr));
    chk("estouro", 32'(estouro), 32'(m_ov));
    chk("unidade", 32'(unidade), 32'(m_u));
    chk("dezena", 32'(dezena), 32'(m_d));
    chk("centena", 32'(centena), 32'(m_c));
    chk("seg_unidade", 32'(seg_unidade), 32'(seg_esp(m_u)));
    chk("seg_dezena", 32'(seg_dezena), 32'(seg_esp(m_d)));
    chk("seg_centena", 32'(seg_centena), 32'(seg_esp(m_c)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 2'b00, 32'd0);
  endtask

  task automatic wr(input int v);
    tick(1'b0, 2'b01, 32'(v));
  endtask

  initial begin
    int p0;
    reset = 1'b1;
    entradaSaidaControl = 2'b00;
    dadosEscrita = 32'd0;

    tick(1'b1, 2'b00, 32'd0);
    tick(1'b1, 2'b00, 32'd0);
    chk("rst_digits", {20'd0, centena, dezena, unidade}, 32'd0);
    chk("rst_flags", {29'd0, ocupado, pronto, estouro}, 32'd0);
    idle(2);

    // Non-write command codes are ignored.
    tick(1'b0, 2'b10, 32'd5);
    tick(1'b0, 2'b00, 32'd7);
    tick(1'b0, 2'b11, 32'd9);
    chk("ignored_ocupado", 32'(ocupado), 32'd0);

    // 123 -> 1/2/3, units glyph active-low "3".
    p0 = n_pronto;
    wr(123);
    idle(12);
    chk("d123_digits", {20'd0, centena, dezena, unidade}, 32'h123);
    chk("d123_seg", 32'(seg_unidade), 32'h30);
    chk("d123_pulses", 32'(n_pronto - p0), 32'd1);

    // Saturation and its clearing.
    wr(1000);
    idle(12);
    chk("sat_digits", {20'd0, centena, dezena, unidade}, 32'h999);
    chk("sat_estouro", 32'(estouro), 32'd1);
    wr(7);
    idle(12);
    chk("seven_digits", {20'd0, centena, dezena, unidade}, 32'h007);
    chk("seven_estouro", 32'(estouro), 32'd0);

    // Pending overwrite: 45, then 67 at T+3, 89 at T+5.
    p0 = n_pronto;
    wr(45); idle(2); wr(67); idle(1); wr(89);
    idle(25);
    chk("pend_pulses", 32'(n_pronto - p0), 32'd2);
    chk("pend_digits", {20'd0, centena, dezena, unidade}, 32'h089);

    // Write coincident with the update edge.
    wr(250); idle(10); wr(31);
    chk("coinc_first", {20'd0, centena, dezena, unidade}, 32'h250);
    chk("coinc_busy", 32'(ocupado), 32'd1);
    idle(11);
    chk("coinc_second", {20'd0, centena, dezena, unidade}, 32'h031);

    // Reset mid-conversion aborts; later write converts normally.
    p0 = n_pronto;
    wr(512); idle(3);
    tick(1'b1, 2'b00, 32'd0);
    idle(1);
    chk("abort_flags", {29'd0, ocupado, pronto, estouro}, 32'd0);
    chk("abort_digits", {20'd0, centena, dezena, unidade}, 32'd0);
    idle(10);
    chk("abort_pulses", 32'(n_pronto - p0), 32'd0);
    wr(8); idle(12);
    chk("after_abort", {20'd0, centena, dezena, unidade}, 32'h008);

    // A write during reset is dropped.
    tick(1'b1, 2'b01, 32'd77);
    idle(1);
    chk("rst_write_busy", 32'(ocupado), 32'd0);

    // Random traffic with occasional reset and over-range data.
    for (int i = 0; i < 600; i++) begin
      logic [1:0]  c;
      logic [31:0] d;
      logic        r;
      int          k;
      k = int'($urandom_range(0, 9));
      c = (k < 3) ? 2'b01 : 2'($urandom_range(0, 3));
      d = $urandom;
      if ($urandom_range(0, 7) == 0) d[9:0] = 10'(1000 + $urandom_range(0, 23));
      r = ($urandom_range(0, 99) == 0);
      tick(r, c, d);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/saida_display.md
SAIDA_DISPLAY -- requirements
Module: saida_display

Interface
REQ-001 The block SHALL have one clock and reset SHALL be synchronous and active-high: port clk is the single clock and port reset is the synchronous active-high reset.
REQ-002 Parameter LARGURA, default 10: width of the captured binary operand, taken from dadosEscrita[LARGURA-1:0].
REQ-003 Parameter SEG_ATIVO_BAIXO, default 1: when 1, segment outputs are active-low; when 0, active-high.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port reset, input, 1 bit: synchronous active-high reset.
REQ-006 Port dadosEscrita, input, 32 bits: processor write data.
REQ-007 Port entradaSaidaControl, input, 2 bits: I/O command; 2'b01 means output write; all other codes are ignored.
REQ-008 Port unidade, dezena, centena, output, 4 bits each: registered BCD digits of the last completed conversion.
REQ-009 Port seg_unidade, seg_dezena, seg_centena, output, 7 bits each: segments {g,f,e,d,c,b,a} for each digit.
REQ-010 Port ocupado, output, 1 bit: conversion in progress.
REQ-011 Port pronto, output, 1 bit: one-cycle pulse when the digits update.
REQ-012 Port estouro, output, 1 bit: the displayed value was saturated.

Function
REQ-013 A write SHALL be sampled on any rising edge where entradaSaidaControl==2'b01.
REQ-014 FSM states SHALL be OCIOSO, CONVERTE, and ATUALIZA.
REQ-015 In OCIOSO, a write SHALL load operand=min(dadosEscrita[LARGURA-1:0],999) and clear the BCD accumulator. It SHALL also clear the step counter and enter CONVERTE.
REQ-016 In CONVERTE, each cycle SHALL perform one double-dabble step: add 3 to each BCD nibble >=5, then shift {bcd,operand} left by one.
REQ-017 After LARGURA steps, the FSM SHALL enter ATUALIZA. For LARGURA=10 this is at edge T+10, where T is the write edge.
REQ-018 In ATUALIZA (edge T+11), unidade/dezena/centena and estouro SHALL be registered and pronto SHALL pulse high for exactly one cycle. The FSM SHALL then go to OCIOSO, or to CONVERTE if a write is pending.
REQ-019 ocupado SHALL be 1 in CONVERTE and ATUALIZA and 0 in OCIOSO.
REQ-020 Digits SHALL hold their old value throughout a conversion; no partial result is ever visible.
REQ-021 A one-entry pending buffer SHALL capture a write that arrives while ocupado=1.
REQ-022 A further write while the pending buffer is full SHALL overwrite it, so the newest value wins.
REQ-023 A write in the same cycle as ATUALIZA SHALL be treated as pending and start immediately after, with no lost write.
REQ-024 When restarting from the pending buffer, the buffer SHALL be cleared in the same edge as the new load.
REQ-025 estouro SHALL be 1 when the captured dadosEscrita[LARGURA-1:0] > 999; the displayed digits are then 9,9,9.
REQ-026 Segments SHALL be decoded combinationally from the registered digits: 0-9 standard glyphs, 10-15 blank. Output polarity SHALL follow SEG_ATIVO_BAIXO.

Reset
REQ-027 Reset SHALL force state OCIOSO, ocupado=0, pronto=0, estouro=0, unidade=dezena=centena=0, and the pending buffer empty.
REQ-028 Reset asserted mid-conversion SHALL abort the conversion and discard the pending write; the digits read 0.
REQ-029 A write coincident with reset SHALL be ignored.

Structure
REQ-030 A shared package SHALL hold the state encoding, the constant MAX_DISPLAY=999, the command code CMD_SAIDA=2'b01, and the 7-segment glyph table.
REQ-031 One sub-module, sete_segmentos (4-bit digit in, 7-bit segments out, polarity parameter), SHALL be instantiated three times.

Verification
REQ-032 Write 123 at edge T: ocupado=1 from T+1 to T+11, pronto at T+11, digits 1/2/3, seg_unidade=7'b0110000 (active-low "3").
REQ-033 Write 1000: digits 9/9/9, estouro=1. A subsequent write of 7 gives 0/0/7 with estouro=0.
REQ-034 Write 45, then 67 at T+3, then 89 at T+5: two pronto pulses; the digits show 045, then 089; 67 is never displayed.
REQ-035 Write 250, then a write of 31 coincident with ATUALIZA: 250 appears at T+11 and 031 eleven cycles later, with ocupado continuously high.
REQ-036 Write 512, assert reset at T+4: all outputs 0 at T+5, no pronto pulse, and a later write of 8 converts normally.
REQ-037 entradaSaidaControl=2'b10 or 2'b00 with any data: no state change and ocupado stays 0.
